// File: rtl/fsm_arbiter.sv
// rtl/fsm_arbiter.sv - round-robin burst scheduler sharing one fsm datapath among requesters
module fsm_arbiter #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    input  logic [N_REQ*7-1:0]       req_cond,
    input  logic                     hold,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [2:0]               rsp_y,
    output logic                     busy,
    output logic                     fsm_en,
    output logic [6:0]               fsm_i,
    input  logic [2:0]               fsm_y
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [LEN_W-1:0]   cnt;
    logic [6:0]         cond;

    logic [SUM_W-1:0]   sum;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [LEN_W-1:0]   win_len;
    logic [LEN_W-1:0]   load_len;
    logic [6:0]         win_cond;
    logic [N_REQ-1:0]   win_oh;
    logic [N_REQ-1:0]   owner_oh;

    // Pick the first requester at or after ptr, wrapping; later (lower-offset) hits override earlier ones
    always_comb begin
        sum       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            if (req[sum[IDX_W-1:0]]) begin
                win_idx   = sum[IDX_W-1:0];
                win_found = 1'b1;
            end
        end
        win_len  = req_len[win_idx*LEN_W +: LEN_W];
        win_cond = req_cond[win_idx*7 +: 7];
        load_len = (win_len == '0) ? LEN_W'(1) : win_len;
        win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    end

    // The only combinational path to the fsm: hold gates the enable while a burst runs
    assign fsm_en = (state == S_RUN) && !hold;

    // Burst sequencing with registered grant, done, response and condition outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            cond  <= '0;
            gnt   <= '0;
            done  <= '0;
            rsp_y <= '0;
            busy  <= 1'b0;
            fsm_i <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        owner <= win_idx;
                        cnt   <= load_len;
                        cond  <= win_cond;
                        gnt   <= win_oh;
                        fsm_i <= win_cond;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            fsm_i <= '0;
                            state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    rsp_y <= fsm_y;
                    done  <= owner_oh;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_arbiter.sv
// tb/tb_fsm_arbiter.sv - scoreboard bench for fsm_arbiter with randomized requesters
module tb_fsm_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req;
    logic [N*LW-1:0]   req_len;
    logic [N*7-1:0]    req_cond;
    logic              hold;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [2:0]        rsp_y;
    logic              busy;
    logic              fsm_en;
    logic [6:0]        fsm_i;
    logic [2:0]        fsm_y;

    fsm_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_len  (req_len),
        .req_cond (req_cond),
        .hold     (hold),
        .gnt      (gnt),
        .done     (done),
        .rsp_y    (rsp_y),
        .busy     (busy),
        .fsm_en   (fsm_en),
        .fsm_i    (fsm_i),
        .fsm_y    (fsm_y)
    );

    always #5 clock = ~clock;

    // Stand-in fsm: y advances by 1 + i[2:0] on each enabled edge
    always @(posedge clock or posedge reset) begin
        if (reset) fsm_y <= 3'd0;
        else if (fsm_en) fsm_y <= fsm_y + 3'd1 + fsm_i[2:0];
    end

    typedef struct {
        int         idx;
        logic [6:0] cond;
        int         len;
        logic [2:0] y;
        int         c;
        int         holds;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         en_cnt = 0;
    bit         mon_on = 1'b0;

    // Reference model: phase 0 idle, 1 bursting, 2 settling, 3 reporting
    int         m_phase;
    int         m_ptr;
    int         m_rem;
    int         m_owner;
    logic [2:0] m_y;
    int         now_phase;
    logic       now_hold;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endfunction

    function automatic void model_reset();
        m_phase   = 0;
        m_ptr     = 0;
        m_rem     = 0;
        m_owner   = 0;
        m_y       = 3'd0;
        now_phase = 0;
        now_hold  = 1'b0;
        en_cnt    = 0;
        q.delete();
    endfunction

    function automatic void model_step();
        exp_t e;
        int   w;
        int   tmp;
        now_phase = m_phase;
        now_hold  = hold;
        case (m_phase)
            0: if (req != '0) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                end
                e.idx   = w;
                e.cond  = req_cond[w*7 +: 7];
                e.len   = int'(req_len[w*LW +: LW]);
                if (e.len == 0) e.len = 1;
                tmp     = int'(m_y) + e.len * (1 + int'(e.cond[2:0]));
                e.y     = tmp[2:0];
                e.c     = cyc;
                e.holds = 0;
                m_y     = e.y;
                q.push_back(e);
                m_owner = w;
                m_rem   = e.len;
                m_phase = 1;
            end
            1: begin
                if (hold) q[q.size()-1].holds = q[q.size()-1].holds + 1;
                else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_phase = 2;
                end
            end
            2: m_phase = 3;
            default: begin
                m_ptr   = (m_owner + 1) % N;
                m_phase = 0;
            end
        endcase
    endfunction

    task automatic next();
        if (!reset) model_step();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) next();
    endtask

    // Monitor: per-cycle protocol checks plus scoreboard pop on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_on && !reset) begin
                chk("gnt_onehot", ($countones(gnt) <= 1), 1);
                chk("busy", busy, (now_phase != 0));
                chk("fsm_en", fsm_en, (now_phase == 1 && !now_hold));
                chk("done_phase", (done != '0), (now_phase == 3));
                if (now_phase == 0) chk("gnt_idle", gnt, 0);
                if (now_phase == 1) begin
                    if (q.size() == 0) fail("run_without_grant");
                    else begin
                        chk("fsm_i_run", fsm_i, q[0].cond);
                        chk("gnt_owner", gnt, 32'(1) << q[0].idx);
                    end
                end else begin
                    chk("fsm_i_quiet", fsm_i, 0);
                end
                if (fsm_en) en_cnt++;
                if (done != '0) begin
                    if (q.size() == 0) fail("done_unexpected");
                    else begin
                        e = q.pop_front();
                        chk("done_owner", done, 32'(1) << e.idx);
                        chk("rsp_y", rsp_y, e.y);
                        chk("en_cycles", en_cnt, e.len);
                        chk("done_latency", cyc, e.c + e.len + 2 + e.holds);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized requester traffic
    initial begin
        req = '0; req_len = '0; req_cond = '0; hold = 1'b0;
        model_reset();
        repeat (16) @(posedge clock);
        @(negedge clock);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fsm_en", fsm_en, 0);
        chk("rst_fsm_i", fsm_i, 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        // Single burst, owner condition changed mid-burst
        req_len[0 +: LW] = 4'd5;
        req_cond[0 +: 7] = 7'h7F;
        req = 4'b0001;
        run(2);
        req_cond[0 +: 7] = 7'h00;
        run(5);
        req = '0;
        run(4);

        // All four requesting, length 2
        for (int k = 0; k < N; k++) begin
            req_len[k*LW +: LW] = 4'd2;
            req_cond[k*7 +: 7]  = 7'($urandom);
        end
        req = 4'hF;
        run(22);
        req = '0;
        run(6);

        // Zero length
        req_len[4 +: LW] = 4'd0;
        req = 4'b0010;
        run(3);
        req = '0;
        run(4);

        // Hold for 3 cycles after the second run cycle, req dropped mid-burst
        req_len[0 +: LW] = 4'd4;
        req_cond[0 +: 7] = 7'h2B;
        req = 4'b0001;
        run(1);
        req = '0;
        run(2);
        hold = 1'b1;
        run(3);
        hold = 1'b0;
        run(8);

        // Reset in the third cycle of a length-8 burst
        req_len[0 +: LW] = 4'd8;
        req_len[8 +: LW] = 4'd3;
        req = 4'b0001;
        run(3);
        reset = 1'b1;
        #1;
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_fsm_en", fsm_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_rsp_y", rsp_y, 0);
        model_reset();
        run(3);
        req = 4'b0101;
        reset = 1'b0;
        run(12);
        req = '0;
        run(10);

        // Randomized traffic with hold, churn and mid-burst drops
        for (int t = 0; t < 3000; t++) begin
            hold = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 4) == 0) begin
                    req[k] = 1'b1;
                    req_len[k*LW +: LW] = LW'($urandom_range(0, 15));
                    req_cond[k*7 +: 7]  = 7'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    req_cond[k*7 +: 7]  = 7'($urandom);
                    req_len[k*LW +: LW] = LW'($urandom_range(0, 15));
                end
            end
            if (m_phase == 3 && $urandom_range(0, 1) == 0) req[m_owner] = 1'b0;
            if (m_phase == 1 && $urandom_range(0, 19) == 0) req[m_owner] = 1'b0;
            next();
        end

        req  = '0;
        hold = 1'b0;
        run(40);
        chk("queue_drained", q.size(), 0);
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_arbiter.md
# fsm_arbiter

Round-robin scheduler that shares a single 7-state `fsm` datapath among several requesters. Each winning requester gets an exclusive burst:
- the arbiter drives the FSM's `i0..i6` condition lines and `en` for a requested number of cycles;
- it then samples the FSM's 3-bit `y` and returns it to that requester with a one-cycle done pulse.

The block sits between requester logic and the `fsm` instance, and owns all of the FSM's inputs except `clock` and `reset`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `LEN_W`, 4: burst-length field width; lengths 1..2^LEN_W-1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; also drives the FSM's `reset`.
- `req` in N_REQ: level request per requester; held until matching `done`.
- `req_len` in N_REQ*LEN_W: burst length per requester, slice k = `[k*LEN_W +: LEN_W]`; 0 is treated as 1.
- `req_cond` in N_REQ*7: condition vector per requester, slice k = `[k*7 +: 7]`, bit j drives FSM `i<j>`.
- `hold` in 1: pauses an active burst.
- `gnt` out N_REQ: one-hot owner, zero when idle.
- `done` out N_REQ: one-cycle pulse to the owner when its result is valid.
- `rsp_y` out 3: sampled FSM `y`, held until the next `done`.
- `busy` out 1: high in any state other than IDLE.
- `fsm_en` out 1: to FSM `en`.
- `fsm_i` out 7: to FSM `i0..i6`.
- `fsm_y` in 3: from FSM `y`.

## Operation
State machine, encoded in 2 bits:

**IDLE**
- `fsm_en`=0, `fsm_i`=0, `gnt`=0.
- If `req`≠0, choose the winner: the first set bit at or after `ptr`, circular.
- On that edge, latch into `owner`, `cnt` and `cond`:
  - `owner` = winner index.
  - `cnt` = the winner's `req_len`, or 1 if that field is 0.
  - `cond` = the winner's `req_cond`.
- Transition to RUN.

**RUN**
- `gnt[owner]`=1 and `fsm_i`=`cond`.
- `fsm_en` = ~`hold` (combinational).
- Each edge with `hold`=0 decrements `cnt`.
- When `hold`=0 and `cnt`==1, transition to SETTLE.
- With `hold`=1, `cnt` and state are frozen.

**SETTLE**
- `fsm_en`=0, `fsm_i`=0, `gnt` unchanged.
- On the edge, `rsp_y` <= `fsm_y`, then transition to DONE.

**DONE**
- `done[owner]`=1 for exactly this cycle, `gnt` unchanged.
- On the edge, `ptr` <= (`owner`+1) mod N_REQ, then transition to IDLE.

Rules:
- `req`, `req_len` and `req_cond` are sampled only in IDLE. Changes during a burst are ignored, and dropping `req` mid-burst does not abort it.
- A requester still asserting `req` in IDLE after its `done` re-enters arbitration with lowest priority.
- `hold` in IDLE, SETTLE or DONE has no effect.
- Exactly `cnt` cycles of `fsm_en`=1 are delivered per burst, regardless of how many `hold` cycles intervene.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `done`=0, `rsp_y`=0, `busy`=0, `fsm_en`=0, `fsm_i`=0.
  - Internal: state=IDLE, `ptr`=0, `owner`=0, `cnt`=0, `cond`=0.
- Reset asserted mid-burst:
  - `fsm_en` and `gnt` drop asynchronously.
  - No `done` is issued, and `rsp_y` returns to 0.
- Latency with no hold, from the IDLE edge that samples `req` to the `done` cycle:
  - The edge moves to RUN; RUN lasts L cycles, SETTLE 1 cycle, DONE 1 cycle.
  - `done` is high in cycle L+2 after the sampling edge.
  - The next grant is possible in cycle L+4.
- Per-transaction occupancy is L+3 cycles including IDLE.
- `rsp_y` reflects the FSM after the last enabled edge: the FSM's registered `y` is valid in SETTLE.
- Simultaneous requests:
  - Exactly one winner per IDLE.
  - With all N_REQ requesting, service order is ptr, ptr+1, … (mod N_REQ); no requester waits more than N_REQ−1 bursts.
- `gnt` is registered and `done` is state-decoded; neither has combinational paths from `req`.
- `fsm_en` has a single combinational path, from `hold`.

## Test plan
- **Single burst.** Reset for 16 cycles. Then `req`=0001, `req_len[0]`=5, `req_cond[0]`=7'h7F.
  - Required: `fsm_en` high exactly 5 consecutive cycles with `fsm_i`=7'h7F.
  - `done[0]` one cycle, 7 cycles after the sampling edge.
  - `rsp_y` equals `fsm_y` as it was during SETTLE.
- **All four requesting** continuously, each with len 2.
  - Required: grants 0,1,2,3,0 in that order, each transaction 5 cycles; `gnt` always one-hot or zero.
- **Zero length.** `req_len`=0.
  - Required: exactly 1 cycle of `fsm_en`; `done` 3 cycles after sampling.
- **Hold.** len 4, with `hold`=1 for 3 cycles after the second RUN cycle.
  - Required: exactly 4 `fsm_en` cycles total; `done` delayed by exactly 3 cycles; `fsm_i` stays at `cond` during the hold.
- **Reset mid-RUN.** Assert `reset` in the third cycle of a len-8 burst.
  - Required: `fsm_en`, `gnt` and `busy` go to 0 immediately; no `done`; after release `ptr`=0 and req 0 wins first.
- **Request churn.**
  - Change `req_cond` of the owner mid-burst → `fsm_i` unchanged.
  - Drop `req` mid-burst → burst completes and `done` still pulses.
